// File: rtl/adsr_pkg.sv
// Shared types and register map for the ADSR envelope bank.
// Voice state codes double as the STATUS register field values.
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  typedef enum logic [1:0] {
    SWEEP_IDLE = 2'd0,
    SWEEP_RUN  = 2'd1,
    SWEEP_DONE = 2'd2
  } sweep_state_e;

  localparam int STATUS_W = 3;

  // Word offsets inside a voice's 16-byte register block
  localparam logic [1:0] OFS_ATTACK_RATE  = 2'd0;
  localparam logic [1:0] OFS_DECAY_RATE   = 2'd1;
  localparam logic [1:0] OFS_SUSTAIN_LVL  = 2'd2;
  localparam logic [1:0] OFS_RELEASE_RATE = 2'd3;

  localparam logic [15:0] ADDR_GATE       = 16'h0100;
  localparam logic [15:0] ADDR_STATUS     = 16'h0104;
  localparam logic [15:0] ADDR_LEVEL_BASE = 16'h0200;

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/adsr_voice_step.sv
// One envelope step for a single voice: gate-edge handling followed by the
// rate update of the resulting state. Purely combinational, shared by the sweep.
module adsr_voice_step
  import adsr_pkg::*;
#(
  parameter int LEVEL_W = 16
) (
  input  logic [STATUS_W-1:0] state_i,
  input  logic [LEVEL_W-1:0]  level_i,
  input  logic                gate_i,
  input  logic                gate_prev_i,
  input  logic [LEVEL_W-1:0]  attack_i,
  input  logic [LEVEL_W-1:0]  decay_i,
  input  logic [LEVEL_W-1:0]  sustain_i,
  input  logic [LEVEL_W-1:0]  release_i,
  output logic [STATUS_W-1:0] state_o,
  output logic [LEVEL_W-1:0]  level_o
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  adsr_state_e      cur_state;
  adsr_state_e      eff_state;
  adsr_state_e      nxt_state;
  logic [LEVEL_W:0] attack_sum;

  always_comb begin
    cur_state = adsr_state_e'(state_i);
    eff_state = cur_state;
    // The edge tick already applies the new phase's step, starting from the current level
    if (gate_i && !gate_prev_i) begin
      eff_state = ST_ATTACK;
    end else if (!gate_i && gate_prev_i &&
                 (cur_state == ST_ATTACK || cur_state == ST_DECAY || cur_state == ST_SUSTAIN)) begin
      eff_state = ST_RELEASE;
    end

    attack_sum = {1'b0, level_i} + {1'b0, attack_i};
    nxt_state  = eff_state;
    level_o    = level_i;

    case (eff_state)
      ST_ATTACK: begin
        if (attack_i != '0) begin
          if (attack_sum >= {1'b0, LEVEL_MAX}) begin
            level_o   = LEVEL_MAX;
            nxt_state = ST_DECAY;
          end else begin
            level_o = attack_sum[LEVEL_W-1:0];
          end
        end
      end
      ST_DECAY: begin
        if (decay_i != '0) begin
          if ((level_i <= sustain_i) || ((level_i - sustain_i) <= decay_i)) begin
            level_o   = sustain_i;
            nxt_state = ST_SUSTAIN;
          end else begin
            level_o = level_i - decay_i;
          end
        end
      end
      ST_SUSTAIN: level_o = sustain_i;
      ST_RELEASE: begin
        if (release_i != '0) begin
          if (level_i <= release_i) begin
            level_o   = '0;
            nxt_state = ST_IDLE;
          end else begin
            level_o = level_i - release_i;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign state_o = nxt_state;

endmodule

// File: rtl/adsr_envelope_bank.sv
// Bank of ADSR envelope generators behind an Avalon-style register port.
// A single shared step unit walks the voices one per cycle after each sample tick.
module adsr_envelope_bank
  import adsr_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int LEVEL_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   avalon_address,
  input  logic [3:0]                    avalon_byte_enable,
  input  logic                          avalon_read,
  input  logic                          avalon_write,
  input  logic [31:0]                   avalon_write_data,
  output logic                          avalon_acknowledge,
  output logic [31:0]                   avalon_read_data,
  input  logic                          sample_tick,
  output logic [NUM_VOICES*LEVEL_W-1:0] env_level,
  output logic                          env_valid
);

  logic                  ack_q, ack_d, cool_q, cool_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  env_valid_q, env_valid_d;
  logic [NUM_VOICES-1:0] gate_q, gate_d, gate_prev_q, gate_prev_d;
  logic [LEVEL_W-1:0]    attack_q[NUM_VOICES], attack_d[NUM_VOICES];
  logic [LEVEL_W-1:0]    decay_q[NUM_VOICES], decay_d[NUM_VOICES];
  logic [LEVEL_W-1:0]    sustain_q[NUM_VOICES], sustain_d[NUM_VOICES];
  logic [LEVEL_W-1:0]    release_q[NUM_VOICES], release_d[NUM_VOICES];
  logic [LEVEL_W-1:0]    level_q[NUM_VOICES], level_d[NUM_VOICES];
  adsr_state_e           state_q[NUM_VOICES], state_d[NUM_VOICES];
  sweep_state_e          sweep_q, sweep_d;
  logic [2:0]            vidx_q, vidx_d;

  logic                  accept, wr_en, rd_en;
  logic                  is_voice, is_gate, is_status, is_level;
  logic [31:0]           rd_word, merged;
  logic                  step_en;
  logic [2:0]            step_idx;
  logic [STATUS_W-1:0]   sel_state, nxt_state;
  logic [LEVEL_W-1:0]    sel_level, sel_attack, sel_decay, sel_sustain, sel_release, nxt_level;
  logic                  sel_gate, sel_prev;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^avalon_address[1:0];

  // Bus handshake: one-cycle ack, then a forced idle cycle before the next accept
  assign accept = (avalon_read | avalon_write) & ~ack_q & ~cool_q;
  assign wr_en  = accept & avalon_write;
  assign rd_en  = accept & avalon_read & ~avalon_write;

  assign is_voice  = (avalon_address[15:7] == 9'd0) && (int'(avalon_address[6:4]) < NUM_VOICES);
  assign is_gate   = (avalon_address[15:2] == ADDR_GATE[15:2]);
  assign is_status = (avalon_address[15:2] == ADDR_STATUS[15:2]);
  assign is_level  = (avalon_address[15:5] == ADDR_LEVEL_BASE[15:5]) &&
                     (int'(avalon_address[4:2]) < NUM_VOICES);

  always_comb begin
    rd_word = '0;
    if (is_voice) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (avalon_address[6:4] == 3'(v)) begin
          case (avalon_address[3:2])
            OFS_ATTACK_RATE:  rd_word = 32'(attack_q[v]);
            OFS_DECAY_RATE:   rd_word = 32'(decay_q[v]);
            OFS_SUSTAIN_LVL:  rd_word = 32'(sustain_q[v]);
            OFS_RELEASE_RATE: rd_word = 32'(release_q[v]);
          endcase
        end
      end
    end else if (is_gate) begin
      rd_word = 32'(gate_q);
    end else if (is_status) begin
      for (int v = 0; v < NUM_VOICES; v++) rd_word[STATUS_W*v +: STATUS_W] = state_q[v];
    end else if (is_level) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (avalon_address[4:2] == 3'(v)) rd_word = 32'(level_q[v]);
      end
    end
  end

  assign ack_d   = accept;
  assign cool_d  = ack_q;
  assign rdata_d = rd_en ? rd_word : 32'd0;

  // Sweep FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_q <= SWEEP_IDLE;
      vidx_q  <= '0;
    end else begin
      sweep_q <= sweep_d;
      vidx_q  <= vidx_d;
    end
  end

  // Sweep FSM: next state; voice 0 is stepped on the very edge that samples the tick
  always_comb begin
    sweep_d = sweep_q;
    vidx_d  = vidx_q;
    case (sweep_q)
      SWEEP_IDLE: begin
        if (sample_tick) begin
          vidx_d  = 3'd1;
          sweep_d = (NUM_VOICES == 1) ? SWEEP_DONE : SWEEP_RUN;
        end
      end
      SWEEP_RUN: begin
        vidx_d = vidx_q + 3'd1;
        if (int'(vidx_q) == NUM_VOICES - 1) sweep_d = SWEEP_DONE;
      end
      default: begin
        sweep_d = SWEEP_IDLE;
        vidx_d  = '0;
      end
    endcase
  end

  // Sweep FSM: outputs
  always_comb begin
    step_en     = ((sweep_q == SWEEP_IDLE) && sample_tick) || (sweep_q == SWEEP_RUN);
    step_idx    = (sweep_q == SWEEP_RUN) ? vidx_q : 3'd0;
    env_valid_d = (sweep_q == SWEEP_DONE);
  end

  always_comb begin
    sel_state   = ST_IDLE;
    sel_level   = '0;
    sel_attack  = '0;
    sel_decay   = '0;
    sel_sustain = '0;
    sel_release = '0;
    sel_gate    = 1'b0;
    sel_prev    = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (step_idx == 3'(v)) begin
        sel_state   = state_q[v];
        sel_level   = level_q[v];
        sel_attack  = attack_q[v];
        sel_decay   = decay_q[v];
        sel_sustain = sustain_q[v];
        sel_release = release_q[v];
        sel_gate    = gate_q[v];
        sel_prev    = gate_prev_q[v];
      end
    end
  end

  adsr_voice_step #(.LEVEL_W(LEVEL_W)) u_step (
    .state_i     (sel_state),
    .level_i     (sel_level),
    .gate_i      (sel_gate),
    .gate_prev_i (sel_prev),
    .attack_i    (sel_attack),
    .decay_i     (sel_decay),
    .sustain_i   (sel_sustain),
    .release_i   (sel_release),
    .state_o     (nxt_state),
    .level_o     (nxt_level)
  );

  always_comb begin
    attack_d    = attack_q;
    decay_d     = decay_q;
    sustain_d   = sustain_q;
    release_d   = release_q;
    gate_d      = gate_q;
    gate_prev_d = gate_prev_q;
    state_d     = state_q;
    level_d     = level_q;
    merged      = '0;
    if (wr_en && is_voice) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (avalon_address[6:4] == 3'(v)) begin
          case (avalon_address[3:2])
            OFS_ATTACK_RATE: begin
              merged = be_merge(32'(attack_q[v]), avalon_write_data, avalon_byte_enable);
              attack_d[v] = merged[LEVEL_W-1:0];
            end
            OFS_DECAY_RATE: begin
              merged = be_merge(32'(decay_q[v]), avalon_write_data, avalon_byte_enable);
              decay_d[v] = merged[LEVEL_W-1:0];
            end
            OFS_SUSTAIN_LVL: begin
              merged = be_merge(32'(sustain_q[v]), avalon_write_data, avalon_byte_enable);
              sustain_d[v] = merged[LEVEL_W-1:0];
            end
            OFS_RELEASE_RATE: begin
              merged = be_merge(32'(release_q[v]), avalon_write_data, avalon_byte_enable);
              release_d[v] = merged[LEVEL_W-1:0];
            end
          endcase
        end
      end
    end else if (wr_en && is_gate) begin
      merged = be_merge(32'(gate_q), avalon_write_data, avalon_byte_enable);
      gate_d = merged[NUM_VOICES-1:0];
    end
    // The step sees pre-write registers; a write takes effect for later voices of the sweep
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (step_en && (step_idx == 3'(v))) begin
        state_d[v]     = adsr_state_e'(nxt_state);
        level_d[v]     = nxt_level;
        gate_prev_d[v] = gate_q[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q       <= 1'b0;
      cool_q      <= 1'b0;
      rdata_q     <= '0;
      env_valid_q <= 1'b0;
      gate_q      <= '0;
      gate_prev_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        attack_q[v]  <= '0;
        decay_q[v]   <= '0;
        sustain_q[v] <= '0;
        release_q[v] <= '0;
        level_q[v]   <= '0;
        state_q[v]   <= ST_IDLE;
      end
    end else begin
      ack_q       <= ack_d;
      cool_q      <= cool_d;
      rdata_q     <= rdata_d;
      env_valid_q <= env_valid_d;
      gate_q      <= gate_d;
      gate_prev_q <= gate_prev_d;
      attack_q    <= attack_d;
      decay_q     <= decay_d;
      sustain_q   <= sustain_d;
      release_q   <= release_d;
      level_q     <= level_d;
      state_q     <= state_d;
    end
  end

  assign avalon_acknowledge = ack_q;
  assign avalon_read_data   = rdata_q;
  assign env_valid          = env_valid_q;

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_level
    assign env_level[gi*LEVEL_W +: LEVEL_W] = level_q[gi];
  end

endmodule

// File: tb/tb_adsr_envelope_bank.sv
// Scoreboard bench for adsr_envelope_bank: expected read data and envelope
// snapshots are queued as stimulus is driven and compared when the DUT answers.
module tb_adsr_envelope_bank;

  localparam int NV = 4;
  localparam int LW = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [15:0]    avalon_address;
  logic [3:0]     avalon_byte_enable;
  logic           avalon_read;
  logic           avalon_write;
  logic [31:0]    avalon_write_data;
  logic           avalon_acknowledge;
  logic [31:0]    avalon_read_data;
  logic           sample_tick;
  logic [NV*LW-1:0] env_level;
  logic           env_valid;

  int n_checks = 0;
  int n_errors = 0;

  string       rd_tag_q[$];
  logic [31:0] rd_exp_q[$];
  string       env_tag_q[$];
  logic [63:0] env_exp_q[$];
  logic        rd_active = 1'b0;

  always #5 clk = ~clk;

  adsr_envelope_bank #(.NUM_VOICES(NV), .LEVEL_W(LW)) dut (
    .clk                (clk),
    .reset              (reset),
    .avalon_address     (avalon_address),
    .avalon_byte_enable (avalon_byte_enable),
    .avalon_read        (avalon_read),
    .avalon_write       (avalon_write),
    .avalon_write_data  (avalon_write_data),
    .avalon_acknowledge (avalon_acknowledge),
    .avalon_read_data   (avalon_read_data),
    .sample_tick        (sample_tick),
    .env_level          (env_level),
    .env_valid          (env_valid)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard when the DUT produces read data or an envelope frame
  always @(negedge clk) begin
    if (!reset && avalon_acknowledge && rd_active && rd_exp_q.size() > 0)
      check_val(rd_tag_q.pop_front(), {32'd0, avalon_read_data}, {32'd0, rd_exp_q.pop_front()});
    if (!reset && env_valid) begin
      if (env_exp_q.size() == 0) check_val("env_unexpected", {63'd0, env_valid}, 64'd0);
      else begin
        $display("env frame %s: 0x%016h", env_tag_q[0], env_level);
        check_val(env_tag_q.pop_front(), env_level, env_exp_q.pop_front());
      end
    end
  end

  task automatic bus_xfer(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input string tag, input logic [31:0] exp);
    if (rd) begin
      rd_tag_q.push_back(tag);
      rd_exp_q.push_back(exp);
      rd_active = 1'b1;
    end
    @(negedge clk);
    avalon_address     = addr;
    avalon_byte_enable = be;
    avalon_write_data  = wd;
    avalon_read        = rd;
    avalon_write       = wr;
    @(negedge clk);
    check_val({tag, "_ack"}, {63'd0, avalon_acknowledge}, 64'd1);
    $display("bus %s rd=%0d wr=%0d addr=0x%04h be=%b wdata=0x%08h rdata=0x%08h",
             tag, rd, wr, addr, be, wd, avalon_read_data);
    avalon_read  = 1'b0;
    avalon_write = 1'b0;
    @(negedge clk);
    check_val({tag, "_ack_pulse"}, {63'd0, avalon_acknowledge}, 64'd0);
    @(negedge clk);
    rd_active = 1'b0;
  endtask

  task automatic reg_wr(input logic [15:0] addr, input logic [31:0] wd);
    bus_xfer(1'b0, 1'b1, addr, 4'hF, wd, "wr", 32'd0);
  endtask

  task automatic reg_rd(input logic [15:0] addr, input logic [31:0] exp, input string tag);
    bus_xfer(1'b1, 1'b0, addr, 4'hF, 32'd0, tag, exp);
  endtask

  task automatic do_tick(input logic [15:0] l0, input logic [15:0] l1,
                         input logic [15:0] l2, input logic [15:0] l3, input string tag);
    logic got;
    env_tag_q.push_back(tag);
    env_exp_q.push_back({l3, l2, l1, l0});
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (env_valid) got = 1'b1;
    end
    check_val({tag, "_valid_seen"}, {63'd0, got}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_c;
    int cnt;
    logic [15:0] exp_l;

    reset = 1'b1;
    avalon_address = '0;
    avalon_byte_enable = '0;
    avalon_read = 1'b0;
    avalon_write = 1'b0;
    avalon_write_data = '0;
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_env_level", env_level, 64'd0);
    check_val("rst_env_valid", {63'd0, env_valid}, 64'd0);
    check_val("rst_ack", {63'd0, avalon_acknowledge}, 64'd0);
    check_val("rst_rdata", {32'd0, avalon_read_data}, 64'd0);
    reg_rd(16'h0104, 32'h0, "rst_status");
    reg_rd(16'h0200, 32'h0, "rst_level0");

    // Voice 0 attack / decay into sustain
    reg_wr(16'h0000, 32'h4000);
    reg_wr(16'h0004, 32'h1000);
    reg_wr(16'h0008, 32'h8000);
    reg_rd(16'h0000, 32'h4000, "atk_readback");
    reg_wr(16'h0100, 32'h1);
    do_tick(16'h4000, 0, 0, 0, "atk1");
    do_tick(16'h8000, 0, 0, 0, "atk2");
    do_tick(16'hC000, 0, 0, 0, "atk3");
    do_tick(16'hFFFF, 0, 0, 0, "atk_sat");
    reg_rd(16'h0104, 32'h2, "status_decay");
    for (int k = 1; k <= 8; k++) begin
      exp_l = (k < 8) ? 16'(32'hFFFF - 32'h1000 * k) : 16'h8000;
      do_tick(exp_l, 0, 0, 0, $sformatf("decay%0d", k));
    end
    reg_rd(16'h0104, 32'h3, "status_sustain");
    reg_rd(16'h0200, 32'h8000, "level_sustain");

    // Release, retrigger from mid-release, release to idle
    reg_wr(16'h000C, 32'h3000);
    reg_wr(16'h0100, 32'h0);
    do_tick(16'h5000, 0, 0, 0, "rel1");
    reg_rd(16'h0104, 32'h4, "status_release");
    reg_wr(16'h0100, 32'h1);
    do_tick(16'h9000, 0, 0, 0, "retrig");
    reg_rd(16'h0104, 32'h1, "status_retrig");
    reg_wr(16'h0100, 32'h0);
    do_tick(16'h6000, 0, 0, 0, "rel2");
    do_tick(16'h3000, 0, 0, 0, "rel3");
    do_tick(16'h0000, 0, 0, 0, "rel_zero");
    reg_rd(16'h0104, 32'h0, "status_idle");

    // Byte lanes, read+write collision, unmapped and read-only addresses, gate width
    bus_xfer(1'b0, 1'b1, 16'h0010, 4'b0001, 32'hFFFF_FFFF, "be_lane0", 32'd0);
    reg_rd(16'h0010, 32'h00FF, "be_lane0_rd");
    bus_xfer(1'b0, 1'b1, 16'h0014, 4'b0010, 32'hABCD_1234, "be_lane1", 32'd0);
    reg_rd(16'h0014, 32'h1200, "be_lane1_rd");
    bus_xfer(1'b1, 1'b1, 16'h0018, 4'hF, 32'h0000_7777, "rdwr_both", 32'h0);
    reg_rd(16'h0018, 32'h7777, "rdwr_written");
    reg_wr(16'h0300, 32'h1234);
    reg_rd(16'h0300, 32'h0, "unmapped_rd");
    reg_wr(16'h0100, 32'hFFFF_FFFF);
    reg_rd(16'h0100, 32'h000F, "gate_width");
    reg_wr(16'h0100, 32'h0);
    reg_wr(16'h0204, 32'h5555);
    reg_rd(16'h0204, 32'h0, "level_ro");
    reg_wr(16'h001C, 32'h0001_0003);
    reg_rd(16'h001C, 32'h0003, "upper_bits_dropped");

    // Zero rates hold: voice 2 stays in ATTACK at 0, voice 3 holds in DECAY at max
    reg_wr(16'h0030, 32'h8000);
    reg_wr(16'h0100, 32'hC);
    do_tick(0, 0, 16'h0000, 16'h8000, "v3_atk1");
    reg_rd(16'h0104, 32'h240, "status_v2v3_atk");
    do_tick(0, 0, 16'h0000, 16'hFFFF, "v3_atk_sat");
    reg_rd(16'h0104, 32'h440, "status_v3_decay");
    do_tick(0, 0, 16'h0000, 16'hFFFF, "v3_decay_hold");
    reg_rd(16'h0104, 32'h440, "status_hold");

    // Second tick mid-sweep is ignored; env_valid comes 5 cycles after the first tick
    env_tag_q.push_back("sweep_ignore");
    env_exp_q.push_back({16'hFFFF, 16'h0, 16'h0, 16'h0});
    @(negedge clk);
    sample_tick = 1'b1;
    first_c = -1;
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) sample_tick = 1'b0;
      if (c == 2) sample_tick = 1'b1;
      if (c == 3) sample_tick = 1'b0;
      if (env_valid) begin
        cnt++;
        if (first_c < 0) first_c = c;
      end
    end
    $display("sweep timing: env_valid at cycle %0d, pulses %0d", first_c, cnt);
    check_val("valid_latency", 64'(first_c), 64'd5);
    check_val("valid_once", 64'(cnt), 64'd1);

    // Reset during a sweep and a pending read: no ack, no valid, everything cleared
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    avalon_address = 16'h0000;
    avalon_read = 1'b1;
    @(negedge clk);
    check_val("abort_ack", {63'd0, avalon_acknowledge}, 64'd0);
    avalon_read = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (env_valid) cnt++;
    end
    check_val("abort_no_valid", 64'(cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_env_level", env_level, 64'd0);
    reg_rd(16'h0000, 32'h0, "abort_regs_cleared");
    reg_rd(16'h0100, 32'h0, "abort_gate_cleared");

    repeat (2) @(negedge clk);
    check_val("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);
    check_val("env_queue_drained", 64'(env_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
